// File: rtl/uart_recv.sv
// uart_recv -- UART receiver, receive-side counterpart of the SoC UART
// transmitter. Synchronises the serial line, detects a start edge, samples
// each bit at its midpoint and reassembles an MSB-first word of 1..16 bits,
// with optional odd/even parity and 1..4 stop bits. Framing is latched at
// the start edge, so configuration changes mid-frame have no effect.
//
// Optional build macro: UART_RX_MAJORITY_EN -- each bit is the 2-of-3
// majority of three consecutive synchronised samples around the midpoint
// (start-bit check included); rx_done arrives one clock later.
//
// Ports:
//   clk, rstn      system clock, asynchronous active-low reset
//   bps_mode[2:0]  baud code (0/7:9600 1:19200 2:38400 3:115200 4:230400
//                  5:460800 6:921600)
//   data_num[3:0]  data bits minus 1
//   check_mode[1:0] parity: 01 odd, 10 even, 00/11 none
//   stop_num[1:0]  stop bits minus 1
//   uart_en        enables start detection
//   uart_rxd       asynchronous serial input, idle high
//   uart_rx_busy   frame in progress
//   rx_done        one-cycle pulse per completed frame
//   rx_data[15:0]  last word, right-justified, upper bits zero
//   parity_err     parity mismatch of last frame (held)
//   frame_err      a stop bit of last frame sampled 0 (held)
module uart_recv #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  bps_mode,
  input  logic [3:0]  data_num,
  input  logic [1:0]  check_mode,
  input  logic [1:0]  stop_num,
  input  logic        uart_en,
  input  logic        uart_rxd,
  output logic        uart_rx_busy,
  output logic        rx_done,
  output logic [15:0] rx_data,
  output logic        parity_err,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // Bit period is bit_cyc+1 clocks, matching the transmitter.
  function automatic logic [15:0] bit_cyc_of(input logic [2:0] code);
    case (code)
      3'd1:    return 16'(CLK_FREQ / 192 / 100);
      3'd2:    return 16'(CLK_FREQ / 384 / 100);
      3'd3:    return 16'(CLK_FREQ / 1152 / 100);
      3'd4:    return 16'(CLK_FREQ / 2304 / 100);
      3'd5:    return 16'(CLK_FREQ / 4608 / 100);
      3'd6:    return 16'(CLK_FREQ / 9216 / 100);
      default: return 16'(CLK_FREQ / 96 / 100);
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        par_flag_q, par_flag_d;
  logic        frm_flag_q, frm_flag_d;
  logic [2:0]  bps_q, bps_d;
  logic [3:0]  dnum_q, dnum_d;
  logic [1:0]  chk_q, chk_d;
  logic [1:0]  stop_q, stop_d;
  logic        rx_done_q, rx_done_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;

  logic [15:0] bit_cyc, half, start_pt, mask, data_m;
  logic        fall, bit_s, par_en, exp_par, frm_next;

  assign bit_cyc = bit_cyc_of(bps_q);
  assign half    = bit_cyc >> 1;
  assign fall    = rxd_prev_q & ~rxd_s_q;
  assign mask    = 16'hFFFF >> (4'd15 - dnum_q);
  assign data_m  = shreg_q & mask;
  assign par_en  = (chk_q == 2'b01) || (chk_q == 2'b10);
  assign exp_par = (chk_q == 2'b01) ? ~^data_m : ^data_m;

`ifdef UART_RX_MAJORITY_EN
  logic rxd_prev2_q;
  // The start decision is taken one clock late (HALF+1) so the window covers
  // HALF-1..HALF+1; later decisions at bit_cyc inherit the same +1 offset.
  assign start_pt = half + 16'd1;
  assign bit_s    = (rxd_prev2_q & rxd_prev_q) | (rxd_prev2_q & rxd_s_q) |
                    (rxd_prev_q & rxd_s_q);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rxd_prev2_q <= 1'b1;
    else       rxd_prev2_q <= rxd_prev_q;
  end
`else
  assign start_pt = half;
  assign bit_s    = rxd_s_q;
`endif

  assign frm_next = frm_flag_q | ~bit_s;

  always_comb begin
    state_d      = state_q;
    cnt_d        = (state_q == IDLE || cnt_q == bit_cyc) ? '0 : cnt_q + 16'd1;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_flag_d   = par_flag_q;
    frm_flag_d   = frm_flag_q;
    bps_d        = bps_q;
    dnum_d       = dnum_q;
    chk_d        = chk_q;
    stop_d       = stop_q;
    rx_done_d    = 1'b0;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    case (state_q)
      IDLE: if (uart_en && fall) begin
        state_d    = START;
        bps_d      = bps_mode;
        dnum_d     = data_num;
        chk_d      = check_mode;
        stop_d     = stop_num;
        shreg_d    = '0;
        par_flag_d = 1'b0;
        frm_flag_d = 1'b0;
      end
      START: if (cnt_q == start_pt) state_d = bit_s ? IDLE : DATA;
      DATA: if (cnt_q == bit_cyc) begin
        shreg_d = {shreg_q[14:0], bit_s};
        if (bit_cnt_q == dnum_q) state_d = par_en ? PARITY : STOP;
        else                     bit_cnt_d = bit_cnt_q + 4'd1;
      end
      PARITY: if (cnt_q == bit_cyc) begin
        if (bit_s != exp_par) par_flag_d = 1'b1;
        state_d = STOP;
      end
      STOP: if (cnt_q == bit_cyc) begin
        frm_flag_d = frm_next;
        if (bit_cnt_q == {2'b00, stop_q}) begin
          state_d      = IDLE;
          rx_done_d    = 1'b1;
          rx_data_d    = data_m;
          parity_err_d = par_flag_q;
          frame_err_d  = frm_next;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d     = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_flag_q   <= 1'b0;
      frm_flag_q   <= 1'b0;
      bps_q        <= '0;
      dnum_q       <= '0;
      chk_q        <= '0;
      stop_q       <= '0;
      rx_done_q    <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= uart_rxd;
      rxd_s_q      <= rxd_meta_q;
      rxd_prev_q   <= rxd_s_q;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_flag_q   <= par_flag_d;
      frm_flag_q   <= frm_flag_d;
      bps_q        <= bps_d;
      dnum_q       <= dnum_d;
      chk_q        <= chk_d;
      stop_q       <= stop_d;
      rx_done_q    <= rx_done_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign uart_rx_busy = (state_q != IDLE);
  assign rx_done      = rx_done_q;
  assign rx_data      = rx_data_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver. It is the receive-side counterpart of the SoC UART transmitter and uses the same run-time framing controls: baud code, data width, parity mode and stop count.
- It synchronises the serial input, detects the start bit and samples each bit at its midpoint.
- It reassembles an MSB-first data word and reports the word with a one-cycle done pulse plus parity/frame error flags.
- It sits between the UART pad and the APB UART register block.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- bps_mode  input  3  baud code: 0:9600, 1:19200, 2:38400, 3:115200, 4:230400, 5:460800, 6:921600, 7:9600.
- data_num  input  4  data bits minus 1 (1..16 bits).
- check_mode  input  2  parity: 00 none, 01 odd, 10 even, 11 treated as none.
- stop_num  input  2  stop bits minus 1 (1..4 bits).
- uart_en  input  1  receive enable; start detection only while high.
- uart_rxd  input  1  serial input, asynchronous, idle high.
- uart_rx_busy  output  1  high from start-edge detect until return to IDLE.
- rx_done  output  1  one-cycle pulse when a frame completes.
- rx_data  output  16  received word, right-justified, upper bits zero.
- parity_err  output  1  parity mismatch of the last frame; valid with rx_done, held until the next rx_done.
- frame_err  output  1  any stop bit sampled 0 in the last frame; valid with rx_done, held until the next rx_done.

Behaviour:
- Reset values:
  - uart_rx_busy=0, rx_done=0, rx_data=0, parity_err=0, frame_err=0.
  - Synchroniser flops = 1; state = IDLE.
- Baud timing:
  - uart_bps code = 96/192/384/1152/2304/4608/9216.
  - BIT_CYC = CLK_FREQ/uart_bps/100, integer divide.
  - Bit period = BIT_CYC+1 clocks, matching the transmitter.
  - HALF = BIT_CYC>>1.
- Input: 2-flop synchroniser on uart_rxd; rxd_s is the second stage. Falling edge = previous rxd_s is 1 and current rxd_s is 0.
- Sample counter: 16-bit, cleared on every state change, wraps at BIT_CYC.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge while uart_en=1 moves to START, clears the counter, sets busy and latches all configuration inputs. Config changes mid-frame are ignored.
  - START: when the counter reaches HALF, sample the line. 0 moves to DATA; 1 is a false start: return to IDLE with busy=0 and no rx_done.
  - DATA: sample every BIT_CYC+1 clocks after the start midpoint. Shift left, MSB first: shreg <= {shreg[14:0], bit}. After data_num+1 samples, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: sample one bit.
    - Expected odd-parity bit = ~^data; expected even-parity bit = ^data.
    - Mismatch sets the internal parity flag.
  - STOP: sample stop_num+1 bits; any 0 sets the internal frame flag. On the last stop-bit sample:
    - next clock: rx_done=1 for exactly one cycle;
    - rx_data = shreg masked to data_num+1 bits;
    - parity_err and frame_err updated;
    - state = IDLE, busy=0.
- Back-to-back frames: a start edge arriving immediately after the last stop-bit midpoint is accepted; no dead time beyond 1 clock.
- uart_en falling mid-frame: the current frame completes normally; no new start is accepted.
- Break condition (line held low): produces a frame with frame_err=1, then the receiver waits in IDLE for the next falling edge. A line held low causes no repeated frames.
- Reset mid-frame: immediate return to reset values, with no rx_done.

Optional Feature:
- UART_RX_MAJORITY_EN:
  - Defined: each bit value is the 2-of-3 majority of rxd_s at counter values HALF-1, HALF and HALF+1. The start-bit check also uses the majority. rx_done latency grows by 1 clock.
  - Undefined: single sample at HALF.

Test Plan:
- CLK_FREQ=50e6, bps_mode=3 (435 clocks/bit), data_num=7, check_mode=0, stop_num=0, frame 0xA5 -> rx_done one pulse, rx_data=0x00A5, parity_err=0, frame_err=0, busy high for ~10 bit periods.
- data_num=15, check_mode=1 (odd), word 0x8001 with a correct parity bit of 1 -> rx_data=0x8001, parity_err=0. Repeat with parity bit 0 -> parity_err=1.
- data_num=7, stop_num=1, second stop bit driven 0 -> rx_done with frame_err=1. The next clean frame 0x3C -> frame_err=0, rx_data=0x003C.
- A low glitch on uart_rxd of 100 clocks at 115200 -> false start, busy returns to 0, no rx_done. With UART_RX_MAJORITY_EN, a 1-clock low glitch at a data-bit midpoint does not corrupt the data.
- Reset asserted in the middle of DATA -> all outputs 0 immediately. After reset release, the frame 0x55 is received correctly.
- Two back-to-back 8N1 frames 0x12 and 0x34 with zero idle gap, bps_mode=6 -> two rx_done pulses, with rx_data=0x12 then 0x34.
